// File: rtl/fifo_pkg.sv
// Shared types, error-bit indices and the parity helper
// for the parity-protected FIFO controller.
package fifo_pkg;

    localparam int ERR_PAR   = 2;
    localparam int ERR_OVF   = 1;
    localparam int ERR_UNF   = 0;
    localparam int ERR_W     = 3;
    localparam int PAR_MAX_W = 64;

    typedef logic [ERR_W-1:0] err_t;

    // Callers zero-extend the payload; zero bits do not change the XOR.
    function automatic logic par(
        input logic [PAR_MAX_W-1:0] payload,
        input logic                 odd
    );
        return (^payload) ^ odd;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: ADDR_WIDTH address bits plus
// one wrap bit, counting modulo 2*FIFO_DEPTH.
module fifo_ptr #(
    parameter int AW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [AW:0] ptr_o
);

    logic [AW:0] ptr_q;
    logic [AW:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Sequencing controller for the parity-protected FIFO:
// pointers, flags, push/pop acceptance, parity gen/check.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PAYLOAD_W  = 16,
    parameter int ODD_PARITY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [PAYLOAD_W-1:0]  push_data,
    input  logic                  inject_err,
    input  logic                  pop,
    output logic [PAYLOAD_W-1:0]  pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                  parity_err,
    output err_t                  err_sticky,
    input  logic                  clr_err,
    output logic                  mem_en,
    output logic [$clog2(FIFO_DEPTH)-1:0] mem_wr_addr,
    output logic [$clog2(FIFO_DEPTH)-1:0] mem_rd_addr,
    output logic [PAYLOAD_W:0]    mem_wdata,
    input  logic [PAYLOAD_W:0]    mem_rdata
);

    localparam int   ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic ODD        = (ODD_PARITY != 0);

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;

    logic push_acc;
    logic pop_acc;
    logic rd_bad;

    logic [PAR_MAX_W-1:0] wr_ext;
    logic [PAR_MAX_W-1:0] rd_ext;

    logic perr_q;
    logic perr_d;
    err_t err_q;
    err_t err_d;
    err_t err_set;

    fifo_ptr #(.AW(ADDR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (push_acc),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.AW(ADDR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (pop_acc),
        .ptr_o (rd_ptr)
    );

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0])
                && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign count = wr_ptr - rd_ptr;

    // Reset cycle swallows any concurrent request.
    assign pop_acc  = pop & ~empty & ~rst;
    assign push_acc = push & (~full | pop_acc) & ~rst;

    assign mem_en      = push_acc;
    assign mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    always_comb begin
        wr_ext = '0;
        rd_ext = '0;
        wr_ext[PAYLOAD_W-1:0] = push_data;
        rd_ext[PAYLOAD_W-1:0] = mem_rdata[PAYLOAD_W-1:0];
    end

    assign mem_wdata = {par(wr_ext, ODD) ^ inject_err, push_data};
    assign pop_data  = mem_rdata[PAYLOAD_W-1:0];
    assign rd_bad    = par(rd_ext, ODD) != mem_rdata[PAYLOAD_W];

    always_comb begin
        err_set          = '0;
        err_set[ERR_PAR] = pop_acc & rd_bad;
        err_set[ERR_OVF] = push & full & ~pop_acc;
        err_set[ERR_UNF] = pop & empty;
        err_d            = (clr_err ? '0 : err_q) | err_set;
        perr_d           = pop_acc & rd_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            perr_q <= perr_d;
        end
    end

    assign err_sticky = err_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: even- and odd-parity
// instances share stimulus, each with its own memory model.
module tb_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        inject_err = 1'b0;
    logic        clr_err = 1'b0;
    logic [15:0] push_data = '0;

    logic [15:0] pd0, pd1;
    logic        full0, full1, empty0, empty1;
    logic [2:0]  cnt0, cnt1;
    logic        perr0, perr1;
    logic [2:0]  err0, err1;
    logic        en0, en1;
    logic [1:0]  wa0, wa1, ra0, ra1;
    logic [16:0] wd0, wd1, rd0, rd1;

    logic [16:0] m0 [4];
    logic [16:0] m1 [4];

    int nvec = 0;
    int nerr = 0;

    fifo_ctrl #(.FIFO_DEPTH(4), .PAYLOAD_W(16), .ODD_PARITY(0)) dut0 (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data),
        .inject_err(inject_err), .pop(pop), .pop_data(pd0),
        .full(full0), .empty(empty0), .count(cnt0),
        .parity_err(perr0), .err_sticky(err0), .clr_err(clr_err),
        .mem_en(en0), .mem_wr_addr(wa0), .mem_rd_addr(ra0),
        .mem_wdata(wd0), .mem_rdata(rd0)
    );

    fifo_ctrl #(.FIFO_DEPTH(4), .PAYLOAD_W(16), .ODD_PARITY(1)) dut1 (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data),
        .inject_err(inject_err), .pop(pop), .pop_data(pd1),
        .full(full1), .empty(empty1), .count(cnt1),
        .parity_err(perr1), .err_sticky(err1), .clr_err(clr_err),
        .mem_en(en1), .mem_wr_addr(wa1), .mem_rd_addr(ra1),
        .mem_wdata(wd1), .mem_rdata(rd1)
    );

    always @(posedge clk) begin
        if (en0) m0[wa0] <= wd0;
        if (en1) m1[wa1] <= wd1;
    end
    assign rd0 = m0[ra0];
    assign rd1 = m1[ra1];

    task automatic drive(input logic p, input logic [15:0] d,
                         input logic inj, input logic po,
                         input logic c, input logic r);
        push = p; push_data = d; inject_err = inj;
        pop = po; clr_err = c; rst = r;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        push = 0; pop = 0; inject_err = 0; clr_err = 0; rst = 0;
    endtask

    task automatic do_reset;
        drive(0, 16'h0, 0, 0, 0, 1);
        tick;
    endtask

    function automatic logic [15:0] dv(input int i);
        return 16'hC000 + 16'(i);
    endfunction

    task automatic test_reset;
        drive(1, 16'hDEAD, 0, 1, 0, 1);
        nvec++; if (en0 !== 1'b0) begin nerr++; $display("FAIL rst_mem_en got %b want 0", en0); end
        tick;
        nvec++; if (cnt0 !== 3'd0) begin nerr++; $display("FAIL rst_count got %0d want 0", cnt0); end
        nvec++; if (empty0 !== 1'b1) begin nerr++; $display("FAIL rst_empty got %b want 1", empty0); end
        nvec++; if (full0 !== 1'b0) begin nerr++; $display("FAIL rst_full got %b want 0", full0); end
        nvec++; if (perr0 !== 1'b0) begin nerr++; $display("FAIL rst_perr got %b want 0", perr0); end
        nvec++; if (err0 !== 3'b000) begin nerr++; $display("FAIL rst_err got %b want 000", err0); end
        nvec++; if (wa0 !== 2'd0 || ra0 !== 2'd0) begin nerr++; $display("FAIL rst_addr got %0d/%0d want 0/0", wa0, ra0); end
    endtask

    task automatic test_basic;
        do_reset;
        drive(1, 16'h1234, 0, 0, 0, 0);
        nvec++; if (en0 !== 1'b1) begin nerr++; $display("FAIL t1_en got %b want 1", en0); end
        nvec++; if (wd0 !== 17'h11234) begin nerr++; $display("FAIL t1_wdata got %h want 11234", wd0); end
        tick;
        nvec++; if (pd0 !== 16'h1234) begin nerr++; $display("FAIL t1_lat got %h want 1234", pd0); end
        nvec++; if (cnt0 !== 3'd1) begin nerr++; $display("FAIL t1_cnt1 got %0d want 1", cnt0); end
        drive(1, 16'hABCD, 0, 0, 0, 0);
        tick;
        nvec++; if (cnt0 !== 3'd2) begin nerr++; $display("FAIL t1_cnt2 got %0d want 2", cnt0); end
        nvec++; if (pd0 !== 16'h1234) begin nerr++; $display("FAIL t1_head got %h want 1234", pd0); end
        drive(0, 16'h0, 0, 1, 0, 0);
        tick;
        nvec++; if (pd0 !== 16'hABCD) begin nerr++; $display("FAIL t1_pop2 got %h want abcd", pd0); end
        nvec++; if (cnt0 !== 3'd1) begin nerr++; $display("FAIL t1_cnt3 got %0d want 1", cnt0); end
        drive(0, 16'h0, 0, 1, 0, 0);
        tick;
        nvec++; if (cnt0 !== 3'd0 || empty0 !== 1'b1) begin nerr++; $display("FAIL t1_empty got %0d/%b want 0/1", cnt0, empty0); end
        nvec++; if (perr0 !== 1'b0) begin nerr++; $display("FAIL t1_perr got %b want 0", perr0); end
    endtask

    task automatic fill4;
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'h1111 * 16'(i + 1), 0, 0, 0, 0);
            tick;
        end
    endtask

    task automatic test_overflow;
        do_reset;
        fill4;
        nvec++; if (full0 !== 1'b1 || cnt0 !== 3'd4) begin nerr++; $display("FAIL t2_full got %b/%0d want 1/4", full0, cnt0); end
        drive(1, 16'h5555, 0, 0, 0, 0);
        nvec++; if (en0 !== 1'b0) begin nerr++; $display("FAIL t2_en got %b want 0", en0); end
        tick;
        nvec++; if (cnt0 !== 3'd4) begin nerr++; $display("FAIL t2_cnt got %0d want 4", cnt0); end
        nvec++; if (err0 !== 3'b010) begin nerr++; $display("FAIL t2_err got %b want 010", err0); end
        nvec++; if (pd0 !== 16'h1111) begin nerr++; $display("FAIL t2_head got %h want 1111", pd0); end
    endtask

    task automatic test_full_pushpop;
        logic [15:0] exp [4];
        exp[0] = 16'h2222; exp[1] = 16'h3333;
        exp[2] = 16'h4444; exp[3] = 16'h7777;
        do_reset;
        fill4;
        drive(1, 16'h7777, 0, 1, 0, 0);
        nvec++; if (en0 !== 1'b1 || wa0 !== ra0) begin nerr++; $display("FAIL t3_en got %b %0d/%0d want 1 equal", en0, wa0, ra0); end
        tick;
        nvec++; if (cnt0 !== 3'd4 || full0 !== 1'b1) begin nerr++; $display("FAIL t3_cnt got %0d/%b want 4/1", cnt0, full0); end
        nvec++; if (err0 !== 3'b000) begin nerr++; $display("FAIL t3_err got %b want 000", err0); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 16'h0, 0, 1, 0, 0);
            nvec++; if (pd0 !== exp[i]) begin nerr++; $display("FAIL t3_pop%0d got %h want %h", i, pd0, exp[i]); end
            tick;
        end
        nvec++; if (empty0 !== 1'b1) begin nerr++; $display("FAIL t3_empty got %b want 1", empty0); end
        nvec++; if (perr0 !== 1'b0) begin nerr++; $display("FAIL t3_perr got %b want 0", perr0); end
    endtask

    task automatic test_empty_pushpop;
        do_reset;
        drive(1, 16'h0F0F, 0, 1, 0, 0);
        tick;
        nvec++; if (cnt0 !== 3'd1) begin nerr++; $display("FAIL t4_cnt got %0d want 1", cnt0); end
        nvec++; if (err0 !== 3'b001) begin nerr++; $display("FAIL t4_err got %b want 001", err0); end
        nvec++; if (pd0 !== 16'h0F0F) begin nerr++; $display("FAIL t4_data got %h want 0f0f", pd0); end
        drive(0, 16'h0, 0, 1, 0, 0);
        tick;
        nvec++; if (empty0 !== 1'b1) begin nerr++; $display("FAIL t4_empty got %b want 1", empty0); end
    endtask

    task automatic test_parity;
        do_reset;
        drive(1, 16'h0001, 1, 0, 0, 0);
        nvec++; if (wd0 !== 17'h00001) begin nerr++; $display("FAIL t5_wd_even got %h want 00001", wd0); end
        nvec++; if (wd1 !== 17'h10001) begin nerr++; $display("FAIL t5_wd_odd got %h want 10001", wd1); end
        tick;
        drive(0, 16'h0, 0, 1, 0, 0);
        nvec++; if (perr0 !== 1'b0) begin nerr++; $display("FAIL t5_pre got %b want 0", perr0); end
        tick;
        nvec++; if (perr0 !== 1'b1 || perr1 !== 1'b1) begin nerr++; $display("FAIL t5_pulse got %b/%b want 1/1", perr0, perr1); end
        nvec++; if (err0 !== 3'b100 || err1 !== 3'b100) begin nerr++; $display("FAIL t5_err got %b/%b want 100/100", err0, err1); end
        tick;
        nvec++; if (perr0 !== 1'b0 || perr1 !== 1'b0) begin nerr++; $display("FAIL t5_1cyc got %b/%b want 0/0", perr0, perr1); end
        nvec++; if (err0 !== 3'b100) begin nerr++; $display("FAIL t5_hold got %b want 100", err0); end
        drive(0, 16'h0, 0, 0, 1, 0);
        tick;
        nvec++; if (err0 !== 3'b000 || err1 !== 3'b000) begin nerr++; $display("FAIL t5_clr got %b/%b want 000/000", err0, err1); end
        drive(1, 16'h0003, 0, 0, 0, 0);
        nvec++; if (wd1 !== 17'h10003) begin nerr++; $display("FAIL t5_wd3 got %h want 10003", wd1); end
        tick;
        drive(0, 16'h0, 0, 1, 0, 0);
        tick;
        nvec++; if (perr0 !== 1'b0 || perr1 !== 1'b0) begin nerr++; $display("FAIL t5_good got %b/%b want 0/0", perr0, perr1); end
        drive(1, 16'h0001, 1, 0, 0, 0);
        tick;
        drive(0, 16'h0, 0, 1, 1, 0);
        tick;
        nvec++; if (err0 !== 3'b100 || err1 !== 3'b100) begin nerr++; $display("FAIL t5_setwins got %b/%b want 100/100", err0, err1); end
    endtask

    task automatic test_wrap;
        do_reset;
        drive(1, dv(0), 0, 0, 0, 0);
        tick;
        for (int i = 0; i < 10; i++) begin
            drive(1, dv(i + 1), (i == 9), 1, 0, 0);
            nvec++; if (pd0 !== dv(i)) begin nerr++; $display("FAIL t6_pop%0d got %h want %h", i, pd0, dv(i)); end
            tick;
            nvec++; if (cnt0 !== 3'd1) begin nerr++; $display("FAIL t6_cnt%0d got %0d want 1", i, cnt0); end
        end
        drive(1, 16'h9999, 0, 1, 0, 1);
        nvec++; if (en0 !== 1'b0) begin nerr++; $display("FAIL t6_rst_en got %b want 0", en0); end
        tick;
        nvec++; if (cnt0 !== 3'd0 || empty0 !== 1'b1) begin nerr++; $display("FAIL t6_rst got %0d/%b want 0/1", cnt0, empty0); end
        nvec++; if (perr0 !== 1'b0 || err0 !== 3'b000) begin nerr++; $display("FAIL t6_noperr got %b/%b want 0/000", perr0, err0); end
        tick;
        nvec++; if (perr0 !== 1'b0) begin nerr++; $display("FAIL t6_late got %b want 0", perr0); end
        drive(1, 16'hBEEF, 0, 0, 0, 0);
        nvec++; if (wa0 !== 2'd0 || en0 !== 1'b1) begin nerr++; $display("FAIL t6_wa got %0d/%b want 0/1", wa0, en0); end
        tick;
        nvec++; if (ra0 !== 2'd0 || pd0 !== 16'hBEEF) begin nerr++; $display("FAIL t6_rd got %0d/%h want 0/beef", ra0, pd0); end
        drive(0, 16'h0, 0, 1, 0, 0);
        tick;
        nvec++; if (empty0 !== 1'b1 || perr0 !== 1'b0) begin nerr++; $display("FAIL t6_end got %b/%b want 1/0", empty0, perr0); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
        #2;
        test_reset;
        test_basic;
        test_overflow;
        test_full_pushpop;
        test_empty_pushpop;
        test_parity;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
